uart_rx_word_packer: RTL

//  Receive-side stage between UARTModule and the core. Consumes the byte stream UARTModule

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_word_fifo.sv | 44 ++++
 rtl/uart_rx_word_packer.sv | 68 ++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART byte/word widths and byte-lane helpers for the rx packer and tx unpacker.
package uart_pkg;
  localparam int UART_BYTE_W = 8;
  localparam int UART_WORD_W = 32;
  localparam int UART_BYTES_PER_WORD = 4;
  typedef logic [UART_WORD_W-1:0] uart_word_t;
  typedef logic [UART_BYTE_W-1:0] uart_byte_t;
  function automatic uart_word_t set_lane(input uart_word_t w, input logic [1:0] k, input uart_byte_t b);
    uart_word_t r;
    r = w;
    r[int'(k)*UART_BYTE_W +: UART_BYTE_W] = b;
    return r;
  endfunction
  function automatic uart_byte_t get_lane(input uart_word_t w, input logic [1:0] k);
    return w[int'(k)*UART_BYTE_W +: UART_BYTE_W];
  endfunction
endpackage

// File: rtl/uart_word_fifo.sv
// uart_word_fifo: first-word-fall-through FIFO; head reads as zero while empty.
module uart_word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle
  assign wr = push && (!full || pop);
  assign rd = pop && !empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
  always_ff @(posedge clock)
    if (wr) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_rx_word_packer.sv
// uart_rx_word_packer: packs received UART bytes little-endian into 32-bit words and queues them.
module uart_rx_word_packer
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TIMEOUT = 1024,
  parameter int TO_W = 11,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wb_flag,
  input  logic [UART_BYTE_W-1:0] wb_data,
  input  logic                   rd_en,
  input  logic                   flush,
  output logic [UART_WORD_W-1:0] rd_data,
  output logic                   rd_valid,
  output logic [CW-1:0]          count,
  output logic                   overflow,
  output logic [1:0]             byte_phase
);
  localparam int PART_W = UART_WORD_W - UART_BYTE_W;
  logic [PART_W-1:0] part;
  logic [TO_W-1:0] tcnt;
  uart_word_t word;
  logic full, empty, push, pop, expire;
  always_comb begin
    word = set_lane({{UART_BYTE_W{1'b0}}, part}, byte_phase, wb_data);
    push = !flush && wb_flag && byte_phase == 2'd3;
    pop = !flush && rd_en && !empty;
    expire = TIMEOUT != 0 && !wb_flag && byte_phase != 2'd0 && tcnt == TO_W'(TIMEOUT - 1);
  end
  assign rd_valid = !empty;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      byte_phase <= '0;
      part <= '0;
      tcnt <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      byte_phase <= '0;
      part <= '0;
      tcnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (wb_flag) begin
        byte_phase <= byte_phase + 2'd1;
        part <= word[PART_W-1:0];
      end else if (expire) begin
        byte_phase <= '0;
        part <= '0;
      end
      tcnt <= (wb_flag || byte_phase == 2'd0 || expire) ? '0 : tcnt + TO_W'(1);
      if (push && full && !pop) overflow <= 1'b1;
    end
  uart_word_fifo #(.DEPTH(DEPTH), .WIDTH(UART_WORD_W)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(flush),
    .din(word),
    .full(full),
    .empty(empty),
    .count(count),
    .head(rd_data)
  );
endmodule
